control_edicion_campos: RTL and testbench

- Edit-mode sequencer for the time/date setting path. It steps the user through six fields (sec, min, hour, day, month, year).
- It drives the shared up/down data counter by sending single-cycle up/down strobes, the per-field limit (condicion_c2), and the W_R clear.
- It captures each finished field into a register bank, then hands the bank to the RTC writer through a req/ack handshake.

---
 rtl/control_edicion_campos_pkg.sv | 28 ++
 rtl/control_edicion_campos_detector_flanco.sv | 25 ++
 rtl/control_edicion_campos.sv | 162 ++++++++++++++++
 tb/tb_control_edicion_campos.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_edicion_campos_pkg.sv
// Shared definitions for the time/date edit-mode sequencer.
//   state_t     : sequencer states (2-bit encoding)
//   F_*         : field indices in edit order (sec, min, hour, day, month, year)
//   LIM_*       : upper limit of each field, sent to the data counter
package control_edicion_campos_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EDIT   = 2'd1,
      STORE  = 2'd2,
      COMMIT = 2'd3
   } state_t;

   localparam logic [2:0] F_SEG = 3'd0;
   localparam logic [2:0] F_MIN = 3'd1;
   localparam logic [2:0] F_HOR = 3'd2;
   localparam logic [2:0] F_DIA = 3'd3;
   localparam logic [2:0] F_MES = 3'd4;
   localparam logic [2:0] F_ANO = 3'd5;

   localparam int unsigned LIM_SEG = 59;
   localparam int unsigned LIM_MIN = 59;
   localparam int unsigned LIM_HOR = 23;
   localparam int unsigned LIM_DIA = 31;
   localparam int unsigned LIM_MES = 12;
   localparam int unsigned LIM_ANO = 99;

endpackage

// File: rtl/control_edicion_campos_detector_flanco.sv
// Rising-edge detector for one synchronized button level.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   level : synchronized button level
//   rise  : one-clk pulse on a 0->1 transition; a held button gives one pulse
module detector_flanco (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic rise
);

   logic prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= level;
      end
   end

   assign rise = level & ~prev_q;

endmodule

// File: rtl/control_edicion_campos.sv
// Edit-mode sequencer for the time/date setting path.
//   clk, rst          : system clock, asynchronous active-low reset
//   tick              : one-cycle enable pulse, drives the inactivity timeout
//   btn_edit/next/up/down : synchronized button levels
//   cnt_in            : current value of the shared up/down data counter
//   wr_ack            : RTC writer has taken the bank
//   up_pulse/down_pulse : single-cycle strobes to the counter
//   W_R               : counter clear/hold (high holds the counter at 0)
//   condicion_c2      : limit of the selected field
//   field_sel         : index of the field being edited
//   edit_active       : high in EDIT and STORE
//   wr_req            : bank valid, RTC write requested
//   bank_out          : flattened field bank, field 0 in the LSBs
module control_edicion_campos
   import control_edicion_campos_pkg::*;
#(
   parameter int unsigned NUM_FIELDS    = 6,
   parameter int unsigned DW            = 7,
   parameter int unsigned TIMEOUT_TICKS = 30
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic                     btn_edit,
   input  logic                     btn_next,
   input  logic                     btn_up,
   input  logic                     btn_down,
   input  logic [DW-1:0]            cnt_in,
   input  logic                     wr_ack,
   output logic                     up_pulse,
   output logic                     down_pulse,
   output logic                     W_R,
   output logic [DW-1:0]            condicion_c2,
   output logic [2:0]               field_sel,
   output logic                     edit_active,
   output logic                     wr_req,
   output logic [NUM_FIELDS*DW-1:0] bank_out
);

   localparam int unsigned TW         = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [2:0]  LAST_FIELD = 3'(NUM_FIELDS - 1);

   logic edit_rise, next_rise, up_rise, down_rise;

   detector_flanco u_det_edit (.clk(clk), .rst(rst), .level(btn_edit), .rise(edit_rise));
   detector_flanco u_det_next (.clk(clk), .rst(rst), .level(btn_next), .rise(next_rise));
   detector_flanco u_det_up   (.clk(clk), .rst(rst), .level(btn_up),   .rise(up_rise));
   detector_flanco u_det_down (.clk(clk), .rst(rst), .level(btn_down), .rise(down_rise));

   state_t                             state_q;
   logic [2:0]                         field_q;
   logic [NUM_FIELDS-1:0][DW-1:0]      bank_q;
   logic [TW-1:0]                      tmo_q;
   logic                               commit_q;
   logic                               up_q, down_q, w_r_q, edit_act_q, wr_req_q;

   // Outputs are registered alongside the state so they change with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         field_q    <= 3'd0;
         bank_q     <= '0;
         tmo_q      <= '0;
         commit_q   <= 1'b0;
         up_q       <= 1'b0;
         down_q     <= 1'b0;
         w_r_q      <= 1'b1;
         edit_act_q <= 1'b0;
         wr_req_q   <= 1'b0;
      end else begin
         up_q   <= 1'b0;
         down_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (edit_rise) begin
                  state_q    <= EDIT;
                  field_q    <= 3'd0;
                  tmo_q      <= '0;
                  w_r_q      <= 1'b0;
                  edit_act_q <= 1'b1;
               end
            end
            EDIT: begin
               if (edit_rise) begin
                  state_q  <= STORE;
                  commit_q <= 1'b1;
                  tmo_q    <= '0;
                  w_r_q    <= 1'b1;
               end else if (next_rise) begin
                  state_q  <= STORE;
                  commit_q <= (field_q == LAST_FIELD);
                  tmo_q    <= '0;
                  w_r_q    <= 1'b1;
               end else begin
                  // Simultaneous up and down cancel each other.
                  up_q   <= up_rise & ~down_rise;
                  down_q <= down_rise & ~up_rise;
                  if (up_rise || down_rise) begin
                     tmo_q <= '0;
                  end else if (tick) begin
                     if (tmo_q == TW'(TIMEOUT_TICKS - 1)) begin
                        // Abort: discard the session, bank untouched.
                        state_q    <= IDLE;
                        field_q    <= 3'd0;
                        tmo_q      <= '0;
                        w_r_q      <= 1'b1;
                        edit_act_q <= 1'b0;
                     end else begin
                        tmo_q <= tmo_q + TW'(1);
                     end
                  end
               end
            end
            STORE: begin
               bank_q[field_q] <= cnt_in;
               if (commit_q) begin
                  state_q    <= COMMIT;
                  edit_act_q <= 1'b0;
                  wr_req_q   <= 1'b1;
               end else begin
                  state_q <= EDIT;
                  field_q <= field_q + 3'd1;
                  w_r_q   <= 1'b0;
               end
            end
            COMMIT: begin
               if (wr_ack) begin
                  state_q  <= IDLE;
                  field_q  <= 3'd0;
                  commit_q <= 1'b0;
                  wr_req_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      condicion_c2 = '0;
      case (field_q)
         F_SEG:   condicion_c2 = DW'(LIM_SEG);
         F_MIN:   condicion_c2 = DW'(LIM_MIN);
         F_HOR:   condicion_c2 = DW'(LIM_HOR);
         F_DIA:   condicion_c2 = DW'(LIM_DIA);
         F_MES:   condicion_c2 = DW'(LIM_MES);
         F_ANO:   condicion_c2 = DW'(LIM_ANO);
         default: condicion_c2 = '0;
      endcase
   end

   assign up_pulse    = up_q;
   assign down_pulse  = down_q;
   assign W_R         = w_r_q;
   assign field_sel   = field_q;
   assign edit_active = edit_act_q;
   assign wr_req      = wr_req_q;
   assign bank_out    = bank_q;

endmodule

// File: tb/tb_control_edicion_campos.sv
// Scoreboard bench for control_edicion_campos: stimulus pushes expected strobes,
// store events and committed banks; a negedge monitor pops and compares.
module tb_control_edicion_campos;

   localparam int NF = 6;
   localparam int DW = 7;
   localparam int TT = 4;

   logic clk = 1'b0, rst = 1'b0, tick = 1'b0, wr_ack = 1'b0;
   logic btn_edit = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic [DW-1:0]    cnt_in = '0;
   logic             up_pulse, down_pulse, W_R, edit_active, wr_req;
   logic [DW-1:0]    condicion_c2;
   logic [2:0]       field_sel;
   logic [NF*DW-1:0] bank_out;

   control_edicion_campos #(.NUM_FIELDS(NF), .DW(DW), .TIMEOUT_TICKS(TT)) dut (
      .clk(clk), .rst(rst), .tick(tick),
      .btn_edit(btn_edit), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
      .cnt_in(cnt_in), .wr_ack(wr_ack),
      .up_pulse(up_pulse), .down_pulse(down_pulse), .W_R(W_R),
      .condicion_c2(condicion_c2), .field_sel(field_sel), .edit_active(edit_active),
      .wr_req(wr_req), .bank_out(bank_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: field limits and the bank contents the user has stored.
   int lim_tab[NF] = '{59, 59, 23, 31, 12, 99};
   int model_bank[NF] = '{0, 0, 0, 0, 0, 0};

   byte              strobe_q[$];
   int               store_q[$];
   logic [NF*DW-1:0] bank_q[$];

   function automatic logic [NF*DW-1:0] packed_bank();
      logic [NF*DW-1:0] r;
      r = '0;
      for (int i = 0; i < NF; i++) r[i*DW +: DW] = DW'(model_bank[i]);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input bit e, input bit n, input bit u, input bit d, input int hold);
      btn_edit = e; btn_next = n; btn_up = u; btn_down = d;
      repeat (hold) step();
      btn_edit = 0; btn_next = 0; btn_up = 0; btn_down = 0;
      repeat ($urandom_range(1, 2)) step();
   endtask

   task automatic rand_op();
      int op;
      op = $urandom_range(0, 2);
      if (op == 0) strobe_q.push_back("U");
      else if (op == 1) strobe_q.push_back("D");
      press(0, 0, op != 1, op != 0, $urandom_range(1, 3));
   endtask

   task automatic give_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
   endtask

   task automatic store_field(input int f, input int val);
      cnt_in = DW'(val);
      model_bank[f] = val;
      store_q.push_back(f);
   endtask

   task automatic commit_ack();
      for (int i = 0; i < 20 && !wr_req; i++) step();
      check("wr_req_rise", wr_req, 1);
      repeat ($urandom_range(0, 3)) step();
      check("wr_req_hold", wr_req, 1);
      wr_ack = 1'b1;
      step();
      wr_ack = 1'b0;
      check("wr_req_fall", wr_req, 0);
      check("post_commit_outs", {edit_active, W_R}, 2'b01);
      check("post_commit_field", field_sel, 0);
   endtask

   // mode 0: commit after the last field; 1: edit rise at stop_at; 2: edit+next at stop_at
   task automatic run_session(input int stop_at, input int mode, input bit directed,
                              input int force_val);
      press(1, 0, 0, 0, 1);
      for (int f = 0; f < NF; f++) begin
         if (directed) begin
            repeat (3) begin
               strobe_q.push_back("U");
               press(0, 0, 1, 0, 1);
            end
            store_field(f, 3 + f);
         end else begin
            repeat ($urandom_range(0, 3)) rand_op();
            if (f == stop_at && force_val >= 0) store_field(f, force_val);
            else store_field(f, $urandom_range(0, lim_tab[f]));
         end
         if (f == stop_at && mode != 0) begin
            bank_q.push_back(packed_bank());
            press(1, mode == 2, 0, 0, $urandom_range(1, 3));
            commit_ack();
            return;
         end
         if (f == NF - 1) begin
            bank_q.push_back(packed_bank());
            press(0, 1, 0, 0, $urandom_range(1, 3));
            commit_ack();
            return;
         end
         press(0, 1, 0, 0, $urandom_range(1, 3));
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents an event.
   logic prev_wr = 1'b0;
   bit   prev_store = 1'b0;
   always @(negedge clk) begin
      byte e;
      int  f;
      bit  store;
      if (rst) begin
         if (up_pulse || down_pulse) begin
            if (strobe_q.size() == 0) begin
               check("strobe_unexpected", {up_pulse, down_pulse}, 2'b00);
            end else begin
               e = strobe_q.pop_front();
               check("strobe_kind", {up_pulse, down_pulse}, (e == "U") ? 2'b10 : 2'b01);
               check("strobe_in_edit", {edit_active, W_R}, 2'b10);
            end
         end
         store = edit_active && W_R;
         if (store) begin
            check("store_one_cycle", prev_store, 0);
            if (store_q.size() == 0) begin
               check("store_expected", store_q.size(), 1);
            end else begin
               f = store_q.pop_front();
               check("store_field", field_sel, f);
               check("store_limit", condicion_c2, lim_tab[f]);
            end
         end
         prev_store = store;
         if (wr_req && !prev_wr) begin
            if (bank_q.size() == 0) check("commit_expected", bank_q.size(), 1);
            else check("commit_bank", bank_out, bank_q.pop_front());
         end
         prev_wr = wr_req;
      end else begin
         prev_wr    = 1'b0;
         prev_store = 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_strobes", {up_pulse, down_pulse}, 2'b00);
      check("rst_w_r", W_R, 1);
      check("rst_edit_active", edit_active, 0);
      check("rst_wr_req", wr_req, 0);
      check("rst_field_sel", field_sel, 0);
      check("rst_bank", bank_out, 0);
      check("rst_limit", condicion_c2, 59);
      rst = 1'b1;
      step();

      // Rises other than edit are ignored in IDLE.
      press(0, 1, 0, 0, 1);
      press(0, 0, 1, 0, 1);
      press(0, 0, 0, 1, 2);
      check("idle_ignores", {edit_active, W_R, wr_req}, 3'b010);

      // Full directed session: up x3 per field, values 3..8.
      run_session(99, 0, 1, -1);
      check("full_bank", bank_out, {7'd8, 7'd7, 7'd6, 7'd5, 7'd4, 7'd3});

      // Held up gives one strobe; up+down together gives none; edit+next commits.
      press(1, 0, 0, 0, 1);
      strobe_q.push_back("U");
      press(0, 0, 1, 0, 20);
      press(0, 0, 1, 1, 2);
      store_field(0, $urandom_range(0, 59));
      bank_q.push_back(packed_bank());
      press(1, 1, 0, 0, 1);
      commit_ack();

      // Early commit at field 2 with value 17.
      run_session(2, 1, 0, 17);

      repeat (8) run_session($urandom_range(0, NF - 1), $urandom_range(0, 2), 0, -1);

      // Timeout: any rise restarts the count; TT ticks of silence abort.
      press(1, 0, 0, 0, 1);
      store_field(0, $urandom_range(0, 59));
      press(0, 1, 0, 0, 1);
      repeat (TT - 1) give_tick();
      check("tmo_before_limit", edit_active, 1);
      strobe_q.push_back("U");
      press(0, 0, 1, 0, 1);
      repeat (TT - 1) give_tick();
      check("tmo_restarted", edit_active, 1);
      give_tick();
      check("tmo_idle", {edit_active, W_R, wr_req}, 3'b010);
      check("tmo_field", field_sel, 0);
      check("tmo_bank", bank_out, packed_bank());

      // Reset during COMMIT drops the request and clears the bank.
      press(1, 0, 0, 0, 1);
      store_field(0, $urandom_range(1, 59));
      bank_q.push_back(packed_bank());
      press(1, 0, 0, 0, 1);
      for (int i = 0; i < 20 && !wr_req; i++) step();
      check("rc_wr_req", wr_req, 1);
      #2 rst = 1'b0;
      #1;
      for (int i = 0; i < NF; i++) model_bank[i] = 0;
      check("rc_wr_req_drop", wr_req, 0);
      check("rc_w_r", W_R, 1);
      check("rc_bank", bank_out, packed_bank());
      step();
      rst = 1'b1;
      step();
      wr_ack = 1'b1;
      step();
      wr_ack = 1'b0;
      step();
      check("rc_ack_ignored", {wr_req, edit_active}, 2'b00);
      check("rc_field", field_sel, 0);

      repeat (3) step();
      check("strobe_q_empty", strobe_q.size(), 0);
      check("store_q_empty", store_q.size(), 0);
      check("bank_q_empty", bank_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
